// File: rtl/stack_writer.sv
// stack_writer: memory write sequencer for the 6502 core.
// Takes one request from execute: a single-byte STORE or a 1-3 byte stack
// push (PUSH1, PUSH_PC, PUSH_INT). It then emits one memory write per cycle
// and reports each stack pointer decrement to the register file.
// Optional feature macro: STACK_WRITER_UNDERFLOW_EN adds a stack_err output.
// stack_err pulses with done when a push in the sequence wrapped the SP.
module stack_writer #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-REG_WIDTH-1:0] STACK_PAGE = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  data_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [REG_WIDTH-1:0]  p_in,
  input  logic                  brk,
  input  logic [REG_WIDTH-1:0]  sp_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [REG_WIDTH-1:0]  data_out,
  output logic                  we_mem,
  output logic [REG_WIDTH-1:0]  sp_out,
  output logic                  we_sp,
  output logic                  busy,
  output logic                  done
`ifdef STACK_WRITER_UNDERFLOW_EN
  ,
  output logic                  stack_err
`endif
);

  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  localparam logic [1:0] MODE_STORE    = 2'b00;
  localparam logic [1:0] MODE_PUSH1    = 2'b01;
  localparam logic [1:0] MODE_PUSH_PC  = 2'b10;
  localparam logic [1:0] MODE_PUSH_INT = 2'b11;
  localparam logic [REG_WIDTH-1:0] SP_ONE = REG_WIDTH'(1);

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_r_q, addr_r_d;
  logic [REG_WIDTH-1:0]  data_r_q, data_r_d;
  logic [ADDR_WIDTH-1:0] pc_r_q, pc_r_d;
  logic [REG_WIDTH-1:0]  p_r_q, p_r_d;
  logic [REG_WIDTH-1:0]  sp_r_q, sp_r_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic [REG_WIDTH-1:0]  data_out_q, data_out_d;
  logic [REG_WIDTH-1:0]  sp_out_q, sp_out_d;
  logic                  we_mem_q, we_mem_d;
  logic                  we_sp_q, we_sp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef STACK_WRITER_UNDERFLOW_EN
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;
`endif

  // Working copies: in IDLE the first byte comes straight from the inputs
  // so it can be registered on the accept edge; afterwards from the latches.
  logic [1:0]            cur_mode;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [REG_WIDTH-1:0]  cur_data;
  logic [ADDR_WIDTH-1:0] cur_pc;
  logic [REG_WIDTH-1:0]  cur_p;
  logic [REG_WIDTH-1:0]  cur_sp;
  logic [REG_WIDTH-1:0]  p_mod;
  logic [1:0]            last_idx;
  logic [1:0]            idx;
  logic                  emit;

  // Next-state, byte selection and registered output values.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_r_d   = addr_r_q;
    data_r_d   = data_r_q;
    pc_r_d     = pc_r_q;
    p_r_d      = p_r_q;
    sp_r_d     = sp_r_q;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    sp_out_d   = sp_out_q;
    we_mem_d   = 1'b0;
    we_sp_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
`ifdef STACK_WRITER_UNDERFLOW_EN
    wrap_d     = wrap_q;
    err_d      = 1'b0;
`endif
    emit       = 1'b0;
    idx        = 2'd0;

    p_mod    = p_in;
    p_mod[5] = 1'b1;
    p_mod[4] = brk;

    if (state_q == IDLE) begin
      cur_mode = mode;
      cur_addr = addr_in;
      cur_data = data_in;
      cur_pc   = pc_in;
      cur_p    = p_mod;
      cur_sp   = sp_in;
    end else begin
      cur_mode = mode_q;
      cur_addr = addr_r_q;
      cur_data = data_r_q;
      cur_pc   = pc_r_q;
      cur_p    = p_r_q;
      cur_sp   = sp_r_q;
    end

    case (cur_mode)
      MODE_PUSH_PC:  last_idx = 2'd1;
      MODE_PUSH_INT: last_idx = 2'd2;
      default:       last_idx = 2'd0;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          addr_r_d = addr_in;
          data_r_d = data_in;
          pc_r_d   = pc_in;
          p_r_d    = p_mod;
          sp_r_d   = sp_in;
`ifdef STACK_WRITER_UNDERFLOW_EN
          wrap_d   = 1'b0;
`endif
          emit     = 1'b1;
          idx      = 2'd0;
          state_d  = W0;
        end
      end
      W0: begin
        if (last_idx > 2'd0) begin
          emit    = 1'b1;
          idx     = 2'd1;
          state_d = W1;
        end else begin
          state_d = IDLE;
        end
      end
      W1: begin
        if (last_idx > 2'd1) begin
          emit    = 1'b1;
          idx     = 2'd2;
          state_d = W2;
        end else begin
          state_d = IDLE;
        end
      end
      W2:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (emit) begin
      we_mem_d = 1'b1;
      busy_d   = 1'b1;
      done_d   = (idx == last_idx);
      case (cur_mode)
        MODE_STORE, MODE_PUSH1: data_out_d = cur_data;
        MODE_PUSH_PC:  data_out_d = (idx == 2'd0) ? cur_pc[ADDR_WIDTH-1 -: REG_WIDTH]
                                                  : cur_pc[REG_WIDTH-1:0];
        MODE_PUSH_INT: data_out_d = (idx == 2'd0) ? cur_pc[ADDR_WIDTH-1 -: REG_WIDTH]
                                  : (idx == 2'd1) ? cur_pc[REG_WIDTH-1:0] : cur_p;
        default:       data_out_d = cur_data;
      endcase
      if (cur_mode == MODE_STORE) begin
        addr_out_d = cur_addr;
      end else begin
        addr_out_d = {STACK_PAGE, cur_sp};
        sp_out_d   = cur_sp - SP_ONE;
        sp_r_d     = cur_sp - SP_ONE;
        we_sp_d    = 1'b1;
      end
`ifdef STACK_WRITER_UNDERFLOW_EN
      if ((cur_mode != MODE_STORE) && (cur_sp == '0)) begin
        wrap_d = 1'b1;
      end
      err_d = done_d & wrap_d;
`endif
    end
  end

  // State, request latches and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      addr_r_q   <= '0;
      data_r_q   <= '0;
      pc_r_q     <= '0;
      p_r_q      <= '0;
      sp_r_q     <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      sp_out_q   <= '0;
      we_mem_q   <= 1'b0;
      we_sp_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef STACK_WRITER_UNDERFLOW_EN
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_r_q   <= addr_r_d;
      data_r_q   <= data_r_d;
      pc_r_q     <= pc_r_d;
      p_r_q      <= p_r_d;
      sp_r_q     <= sp_r_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      sp_out_q   <= sp_out_d;
      we_mem_q   <= we_mem_d;
      we_sp_q    <= we_sp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef STACK_WRITER_UNDERFLOW_EN
      wrap_q     <= wrap_d;
      err_q      <= err_d;
`endif
    end
  end

  assign addr_out = addr_out_q;
  assign data_out = data_out_q;
  assign sp_out   = sp_out_q;
  assign we_mem   = we_mem_q;
  assign we_sp    = we_sp_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef STACK_WRITER_UNDERFLOW_EN
  assign stack_err = err_q;
`endif

endmodule

// File: tb/tb_stack_writer.sv
// Testbench for stack_writer: reset, a table of known requests, hand-written
// corner sequences (start while busy, reset mid-sequence) and random requests
// checked against a byte-list model of the write sequencer.
module tb_stack_writer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  mode;
   logic [15:0] addr_in;
   logic [7:0]  data_in;
   logic [15:0] pc_in;
   logic [7:0]  p_in;
   logic        brk;
   logic [7:0]  sp_in;
   logic [15:0] addr_out;
   logic [7:0]  data_out;
   logic        we_mem;
   logic [7:0]  sp_out;
   logic        we_sp;
   logic        busy;
   logic        done;
`ifdef STACK_WRITER_UNDERFLOW_EN
   logic        stack_err;
`endif

   int checkCount = 0;
   int failCount  = 0;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  sp;
      logic        weSp;
   } wr_t;

   typedef struct {
      logic [1:0]       mode;
      logic [15:0]      addr;
      logic [7:0]       data;
      logic [15:0]      pc;
      logic [7:0]       p;
      logic             brk;
      logic [7:0]       sp;
      int               n;
      logic [2:0][15:0] ea;
      logic [2:0][7:0]  ed;
      logic [2:0][7:0]  esp;
      logic             eerr;
   } vec_t;

   wr_t   expQ[$];
   logic  expErr;
   logic  [7:0] heldSp;
   vec_t  tbl[6];

   stack_writer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .addr_in(addr_in), .data_in(data_in), .pc_in(pc_in), .p_in(p_in),
      .brk(brk), .sp_in(sp_in), .addr_out(addr_out), .data_out(data_out),
      .we_mem(we_mem), .sp_out(sp_out), .we_sp(we_sp), .busy(busy),
      .done(done)
`ifdef STACK_WRITER_UNDERFLOW_EN
      , .stack_err(stack_err)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Single comparison with failure reporting.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // All outputs in their post-reset state.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " addr_out"}, 32'(addr_out), 32'h0);
      checkOutput({tag, " data_out"}, 32'(data_out), 32'h0);
      checkOutput({tag, " sp_out"}, 32'(sp_out), 32'h0);
      checkOutput({tag, " we_mem"}, 32'(we_mem), 32'h0);
      checkOutput({tag, " we_sp"}, 32'(we_sp), 32'h0);
      checkOutput({tag, " busy"}, 32'(busy), 32'h0);
      checkOutput({tag, " done"}, 32'(done), 32'h0);
`ifdef STACK_WRITER_UNDERFLOW_EN
      checkOutput({tag, " stack_err"}, 32'(stack_err), 32'h0);
`endif
   endtask

   // Byte-list model: which bytes go where, and what SP each push reports.
   task automatic modelBuild(input logic [1:0] m, input logic [15:0] a,
                             input logic [7:0] d, input logic [15:0] pc,
                             input logic [7:0] p, input logic b,
                             input logic [7:0] sp);
      logic [7:0] bytes[$];
      logic [7:0] pp;
      wr_t        w;
      int         s;
      expQ.delete();
      expErr = 1'b0;
      if (m == 2'd0) begin
         w.addr = a; w.data = d; w.sp = heldSp; w.weSp = 1'b0;
         expQ.push_back(w);
      end else begin
         pp = (p & 8'hCF) | 8'h20 | (b ? 8'h10 : 8'h00);
         if (m == 2'd1) bytes.push_back(d);
         else begin
            bytes.push_back(pc[15:8]);
            bytes.push_back(pc[7:0]);
            if (m == 2'd3) bytes.push_back(pp);
         end
         s = int'(sp);
         for (int i = 0; i < bytes.size(); i++) begin
            w.addr = 16'h0100 + 16'((s - i) & 255);
            w.data = bytes[i];
            w.sp   = 8'((s - i - 1) & 255);
            w.weSp = 1'b1;
            if (((s - i) & 255) == 0) expErr = 1'b1;
            expQ.push_back(w);
         end
      end
   endtask

   // Issue one request and check every write cycle plus the idle cycle after.
   task automatic applyStimulus(input string tag, input logic [1:0] m,
                                input logic [15:0] a, input logic [7:0] d,
                                input logic [15:0] pc, input logic [7:0] p,
                                input logic b, input logic [7:0] sp,
                                input bit holdStart);
      logic [15:0] lastAddr;
      logic [7:0]  lastData;
      mode = m; addr_in = a; data_in = d; pc_in = pc; p_in = p; brk = b;
      sp_in = sp; start = 1'b1;
      @(posedge clk); #1;
      start   = holdStart;
      mode    = 2'(holdStart ? 0 : $urandom);
      addr_in = 16'($urandom); data_in = 8'($urandom); pc_in = 16'($urandom);
      p_in    = 8'($urandom);  brk = 1'($urandom);      sp_in = 8'($urandom);
      for (int k = 0; k < expQ.size(); k++) begin
         checkOutput({tag, " addr_out"}, 32'(addr_out), 32'(expQ[k].addr));
         checkOutput({tag, " data_out"}, 32'(data_out), 32'(expQ[k].data));
         checkOutput({tag, " we_mem"}, 32'(we_mem), 32'h1);
         checkOutput({tag, " busy"}, 32'(busy), 32'h1);
         checkOutput({tag, " we_sp"}, 32'(we_sp), 32'(expQ[k].weSp));
         checkOutput({tag, " sp_out"}, 32'(sp_out), 32'(expQ[k].sp));
         checkOutput({tag, " done"}, 32'(done), 32'(k == expQ.size() - 1));
`ifdef STACK_WRITER_UNDERFLOW_EN
         checkOutput({tag, " stack_err"}, 32'(stack_err),
                     32'((k == expQ.size() - 1) && expErr));
`endif
         heldSp   = expQ[k].sp;
         lastAddr = expQ[k].addr;
         lastData = expQ[k].data;
         @(posedge clk); #1;
      end
      start = 1'b0;
      checkOutput({tag, " idle busy"}, 32'(busy), 32'h0);
      checkOutput({tag, " idle we_mem"}, 32'(we_mem), 32'h0);
      checkOutput({tag, " idle we_sp"}, 32'(we_sp), 32'h0);
      checkOutput({tag, " idle done"}, 32'(done), 32'h0);
      checkOutput({tag, " idle addr hold"}, 32'(addr_out), 32'(lastAddr));
      checkOutput({tag, " idle data hold"}, 32'(data_out), 32'(lastData));
   endtask

   task automatic setVec(input int i, input logic [1:0] m, input logic [15:0] a,
                         input logic [7:0] d, input logic [15:0] pc,
                         input logic [7:0] p, input logic b, input logic [7:0] sp,
                         input int n,
                         input logic [15:0] a0, input logic [7:0] d0, input logic [7:0] s0,
                         input logic [15:0] a1, input logic [7:0] d1, input logic [7:0] s1,
                         input logic [15:0] a2, input logic [7:0] d2, input logic [7:0] s2,
                         input logic err);
      tbl[i].mode = m; tbl[i].addr = a; tbl[i].data = d; tbl[i].pc = pc;
      tbl[i].p = p; tbl[i].brk = b; tbl[i].sp = sp; tbl[i].n = n;
      tbl[i].ea[0] = a0; tbl[i].ed[0] = d0; tbl[i].esp[0] = s0;
      tbl[i].ea[1] = a1; tbl[i].ed[1] = d1; tbl[i].esp[1] = s1;
      tbl[i].ea[2] = a2; tbl[i].ed[2] = d2; tbl[i].esp[2] = s2;
      tbl[i].eerr = err;
   endtask

   // Main test sequence.
   initial begin
      int pulses;
      wr_t w;
      reset_n = 1'b0; start = 1'b0; mode = 2'd0; addr_in = '0; data_in = '0;
      pc_in = '0; p_in = '0; brk = 1'b0; sp_in = '0;
      heldSp = 8'h00;

      setVec(0, 2'd0, 16'h1234, 8'hAB, 16'h0000, 8'h00, 1'b0, 8'h00, 1,
             16'h1234, 8'hAB, 8'h00, 16'h0, 8'h0, 8'h0, 16'h0, 8'h0, 8'h0, 1'b0);
      setVec(1, 2'd3, 16'h0000, 8'h00, 16'hC012, 8'h03, 1'b1, 8'hFD, 3,
             16'h01FD, 8'hC0, 8'hFC, 16'h01FC, 8'h12, 8'hFB, 16'h01FB, 8'h33, 8'hFA, 1'b0);
      setVec(2, 2'd2, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 1'b0, 8'h00, 2,
             16'h0100, 8'hBE, 8'hFF, 16'h01FF, 8'hEF, 8'hFE, 16'h0, 8'h0, 8'h0, 1'b1);
      setVec(3, 2'd1, 16'h0000, 8'h5A, 16'h0000, 8'h00, 1'b0, 8'h80, 1,
             16'h0180, 8'h5A, 8'h7F, 16'h0, 8'h0, 8'h0, 16'h0, 8'h0, 8'h0, 1'b0);
      setVec(4, 2'd3, 16'h0000, 8'h00, 16'h1234, 8'hFF, 1'b0, 8'h02, 3,
             16'h0102, 8'h12, 8'h01, 16'h0101, 8'h34, 8'h00, 16'h0100, 8'hEF, 8'hFF, 1'b1);
      setVec(5, 2'd0, 16'hFFFF, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00, 1,
             16'hFFFF, 8'h00, 8'h00, 16'h0, 8'h0, 8'h0, 16'h0, 8'h0, 8'h0, 1'b0);

      // Reset held for two edges.
      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      reset_n = 1'b1;

      // Table of known requests with hand-derived expectations.
      for (int i = 0; i < 6; i++) begin
         expQ.delete();
         expErr = tbl[i].eerr;
         for (int k = 0; k < tbl[i].n; k++) begin
            w.addr = tbl[i].ea[k];
            w.data = tbl[i].ed[k];
            w.weSp = (tbl[i].mode != 2'd0);
            w.sp   = w.weSp ? tbl[i].esp[k] : heldSp;
            expQ.push_back(w);
         end
         applyStimulus($sformatf("vec%0d", i), tbl[i].mode, tbl[i].addr,
                       tbl[i].data, tbl[i].pc, tbl[i].p, tbl[i].brk,
                       tbl[i].sp, 1'b0);
      end

      // start held high during a PUSH_PC: exactly two writes, then idle.
      modelBuild(2'd2, 16'h0, 8'h0, 16'hA55A, 8'h00, 1'b0, 8'h40);
      applyStimulus("busy-start", 2'd2, 16'h0, 8'h0, 16'hA55A, 8'h00, 1'b0,
                    8'h40, 1'b1);
      @(posedge clk); #1;
      checkOutput("busy-start 2nd idle busy", 32'(busy), 32'h0);
      checkOutput("busy-start 2nd idle we_mem", 32'(we_mem), 32'h0);
      modelBuild(2'd0, 16'h2468, 8'h77, 16'h0, 8'h00, 1'b0, 8'h00);
      applyStimulus("after-busy", 2'd0, 16'h2468, 8'h77, 16'h0, 8'h00, 1'b0,
                    8'h00, 1'b0);

      // Reset in the cycle carrying the first PUSH_INT write.
      mode = 2'd3; pc_in = 16'h8001; p_in = 8'h00; brk = 1'b0; sp_in = 8'hF0;
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      pulses = 0;
      if (we_mem) pulses++;
      reset_n = 1'b0;
      @(posedge clk); #1;
      if (we_mem) pulses++;
      checkResetOutputs("midreset");
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (we_mem) pulses++;
         checkOutput("midreset done", 32'(done), 32'h0);
         checkOutput("midreset busy", 32'(busy), 32'h0);
      end
      checkOutput("midreset we_mem pulses", 32'(pulses), 32'd1);
      heldSp = 8'h00;

      // Random requests against the model, with random idle gaps.
      for (int r = 0; r < 60; r++) begin
         logic [1:0]  rm;
         logic [15:0] ra, rpc;
         logic [7:0]  rd, rp, rsp;
         logic        rb;
         int          gap;
         rm  = 2'($urandom);  ra = 16'($urandom); rd = 8'($urandom);
         rpc = 16'($urandom); rp = 8'($urandom);  rb = 1'($urandom);
         rsp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2))
                                           : 8'($urandom);
         modelBuild(rm, ra, rd, rpc, rp, rb, rsp);
         applyStimulus($sformatf("rand%0d", r), rm, ra, rd, rpc, rp, rb, rsp, 1'b0);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            checkOutput("gap we_mem", 32'(we_mem), 32'h0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checkCount, failCount);
      $finish;
   end

endmodule
